ahb_bus_arbiter: RTL

//   Shares the single AHB-lite master port (ram_* interface) between the instruction-fetch (I) and load/store (D) units.
//   Per transaction: arbitrates, issues the address phase, holds address/size/write data through the data phase,

---
 rtl/ahb_bus_arbiter_if.sv | 38 +++
 rtl/ahb_bus_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter_if.sv
// Bundle of the core-side request/response signals and the AHB-lite master-side
// signals that the arbiter sits between.
// slave  : arbiter view (serves the I/D requesters, drives the master port)
// master : environment view (I/D units and the AHB master)
interface ahb_bus_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rd_data;
  logic        i_ready;
  logic        d_rd_en;
  logic        d_wd_en;
  logic [31:0] d_addr;
  logic [2:0]  d_size;
  logic [31:0] d_wd_data;
  logic [31:0] d_rd_data;
  logic        d_ready;
  logic        d_err;
  logic [31:0] m_addr;
  logic [2:0]  m_size;
  logic        m_rd_en;
  logic        m_wd_en;
  logic [31:0] m_wd_data;
  logic [31:0] m_rd_data;
  logic        m_ready;
  logic [1:0]  grant;

  modport slave (
    input  i_req, i_addr, d_rd_en, d_wd_en, d_addr, d_size, d_wd_data, m_rd_data, m_ready,
    output i_rd_data, i_ready, d_rd_data, d_ready, d_err,
           m_addr, m_size, m_rd_en, m_wd_en, m_wd_data, grant
  );

  modport master (
    output i_req, i_addr, d_rd_en, d_wd_en, d_addr, d_size, d_wd_data, m_rd_data, m_ready,
    input  i_rd_data, i_ready, d_rd_data, d_ready, d_err,
           m_addr, m_size, m_rd_en, m_wd_en, m_wd_data, grant
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Shares one AHB-lite master port between the instruction-fetch (I) and
// load/store (D) units, one transaction outstanding at a time.
// Flow: IDLE -> ADDR (1 cycle, enables high) -> DATA (wait for m_ready or timeout).
// Completion re-arbitrates in the same cycle so a waiting requester goes straight
// to ADDR with no IDLE gap; the side completing is not eligible in that cycle.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration
// (default build: fixed priority, D over I).
module ahb_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_W           = 9
) (
  input  logic              hclk,
  input  logic              hreset_n,
  ahb_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TO_W-1:0] r_cnt;

  logic w_own_i;
  logic w_own_d;
  logic w_to_hit;
  logic w_done;
  logic w_to;
  logic w_arb;
  logic w_i_elig;
  logic w_d_elig;
  logic w_start;
  logic w_win_d;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = D owned the bus last, 0 = I (reset value)
  logic r_last_d;
`endif

  // Arbitration: who may be granted this cycle, and who wins
  always_comb begin
    w_own_i  = (bus.grant == 2'b01);
    w_own_d  = (bus.grant == 2'b10);
    w_to_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_W'(TO_LAST));
    w_done   = (r_state == S_DATA) && bus.m_ready;
    // m_ready wins over a coincident timeout
    w_to     = (r_state == S_DATA) && !bus.m_ready && w_to_hit;
    w_arb    = (r_state == S_IDLE) || w_done;
    w_i_elig = w_arb && bus.i_req && !(w_done && w_own_i);
    w_d_elig = w_arb && (bus.d_rd_en || bus.d_wd_en) && !(w_done && w_own_d);
    w_start  = w_i_elig || w_d_elig;
`ifdef ARB_ROUND_ROBIN_EN
    w_win_d  = w_d_elig && (!w_i_elig || !r_last_d);
`else
    w_win_d  = w_d_elig;
`endif
  end

  // State register
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_ADDR;
      S_ADDR:  w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_done)    w_state_nxt = w_start ? S_ADDR : S_IDLE;
        else if (w_to) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Completion routing back to the granted requester
  always_comb begin
    bus.i_ready   = (w_done || w_to) && w_own_i;
    bus.d_ready   = (w_done || w_to) && w_own_d;
    bus.d_err     = w_to;
    bus.i_rd_data = (w_done && w_own_i) ? bus.m_rd_data : '0;
    bus.d_rd_data = (w_done && w_own_d) ? bus.m_rd_data : '0;
  end

  // Registered master-port outputs and grant
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      bus.m_addr    <= '0;
      bus.m_size    <= '0;
      bus.m_wd_data <= '0;
      bus.m_rd_en   <= 1'b0;
      bus.m_wd_en   <= 1'b0;
      bus.grant     <= '0;
    end else if (w_start) begin
      if (w_win_d) begin
        bus.m_addr    <= bus.d_addr;
        bus.m_size    <= bus.d_size;
        bus.m_wd_data <= bus.d_wd_data;
        bus.m_rd_en   <= bus.d_rd_en;
        bus.m_wd_en   <= bus.d_wd_en;
        bus.grant     <= 2'b10;
      end else begin
        bus.m_addr    <= bus.i_addr;
        bus.m_size    <= 3'd4;
        bus.m_wd_data <= '0;
        bus.m_rd_en   <= 1'b1;
        bus.m_wd_en   <= 1'b0;
        bus.grant     <= 2'b01;
      end
    end else if (r_state == S_ADDR) begin
      bus.m_rd_en <= 1'b0;
      bus.m_wd_en <= 1'b0;
    end else if (w_done || w_to) begin
      bus.grant <= '0;
    end
  end

  // DATA-phase timeout counter, cleared while leaving ADDR
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n)                              r_cnt <= '0;
    else if (r_state == S_ADDR)                 r_cnt <= '0;
    else if (r_state == S_DATA && !bus.m_ready) r_cnt <= r_cnt + 1'b1;
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember the owner of every grant
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n)    r_last_d <= 1'b0;
    else if (w_start) r_last_d <= w_win_d;
  end
`endif

endmodule
